// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: store-and-forward packet FIFO for an 8-bit AXI-Stream link.
// A packet is presented on the master side only once its last beat is stored.
// The exception is a packet too large for the buffer: when the buffer fills
// while holding no complete packet, the FIFO switches to cut-through for that
// packet so the link cannot deadlock.
// The output is first-word-fall-through and is driven straight from the
// storage array at rd_ptr. Every handshake flag is derived from registered
// state only.

module axis_packet_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_axis_data,
  input  logic              s_axis_valid,
  output logic              s_axis_ready,
  input  logic              s_axis_last,
  output logic [DATA_W-1:0] m_axis_data,
  output logic              m_axis_valid,
  input  logic              m_axis_ready,
  output logic              m_axis_last,
  output logic [CW-1:0]     level,
  output logic [CW-1:0]     pkt_count,
  output logic              cut_thru
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE        = CW'(1);

  // Each entry holds {last, data}.
  logic [DATA_W:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] level_q, level_d;
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  logic          cut_thru_q, cut_thru_d;

  logic            wr_en;
  logic            rd_en;
  logic            wr_last;
  logic            rd_last;
  logic [DATA_W:0] rd_word;

  // Handshake flags are functions of registered state only. While full,
  // ready stays low even if a read frees a slot in the same cycle.
  assign s_axis_ready = (level_q != FULL_LEVEL);
  assign m_axis_valid = (level_q != '0) && ((pkt_count_q != '0) || cut_thru_q);

  // First-word-fall-through: the head entry is always on the output.
  assign rd_word     = mem[rd_ptr_q];
  assign m_axis_data = rd_word[DATA_W-1:0];
  assign m_axis_last = rd_word[DATA_W];

  assign level     = level_q;
  assign pkt_count = pkt_count_q;
  assign cut_thru  = cut_thru_q;

  // No beat is taken or handed out on an edge where reset is high.
  assign wr_en   = s_axis_valid && s_axis_ready && !reset;
  assign rd_en   = m_axis_valid && m_axis_ready && !reset;
  assign wr_last = s_axis_last;
  assign rd_last = rd_word[DATA_W];

  // Next-state for pointers, occupancy, packet count and cut-through flag.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pkt_count_d = pkt_count_q;
    cut_thru_d  = cut_thru_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase

    case ({wr_en && wr_last, rd_en && rd_last})
      2'b10:   pkt_count_d = pkt_count_q + ONE;
      2'b01:   pkt_count_d = pkt_count_q - ONE;
      default: pkt_count_d = pkt_count_q;
    endcase

    // The flag rises together with the buffer filling up without a complete
    // packet inside. Reading that packet's last beat ends it and wins over
    // a simultaneous set.
    if ((level_d == FULL_LEVEL) && (pkt_count_d == '0)) begin
      cut_thru_d = 1'b1;
    end
    if (rd_en && rd_last) begin
      cut_thru_d = 1'b0;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pkt_count_q <= '0;
      cut_thru_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pkt_count_q <= pkt_count_d;
      cut_thru_q  <= cut_thru_d;
    end
  end

  // Storage write port. Contents are deliberately not cleared on reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {wr_last, s_axis_data};
    end
  end

endmodule
